spi_rx: RTL and testbench

Synchronous SPI receiver that deserializes one word per chip-select frame from the serial lines driven by the galvo DAC SPI transmitter (sclk/mosi/cs). It serves as the far end of that link for loopback verification and for the downstream board that consumes X/Y samples. All pin inputs are asynchronous to `clock_in`. They are synchronized, edge-detected and shifted into a right-justified parallel word that is qualified by a one-cycle valid strobe.

---
 rtl/spi_rx.sv | 173 +++++++++++++++++
 tb/tb_spi_rx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 receiver (MSB first), one word per chip-select frame.
// All pin inputs are asynchronous to clock_in. They are synchronized and
// edge-detected, then shifted into a right-justified word. Each frame ends
// with either a one-cycle data_valid_out strobe or a one-cycle error_out strobe.
//
// Ports:
//   clock_in        system clock
//   reset_in        synchronous, active-high reset
//   data_length_in  bits per frame, 1..MAX_LENGTH; 0 or >MAX_LENGTH means MAX_LENGTH
//   sclk_in         SPI clock (async, idle low)
//   mosi_in         SPI data (async)
//   cs_in           chip select (async, active low)
//   data_out        last good word, right-justified
//   data_valid_out  one-cycle strobe: data_out updated
//   busy_out        high while a frame is being received
//   error_out       one-cycle strobe: malformed frame (bit count != length)
//   word_count_out  good frames, wraps
//   error_count_out malformed frames, saturates at 255
module spi_rx #(
    parameter int unsigned MAX_LENGTH = 16
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [4:0]            data_length_in,
    input  logic                  sclk_in,
    input  logic                  mosi_in,
    input  logic                  cs_in,
    output logic [MAX_LENGTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  busy_out,
    output logic                  error_out,
    output logic [15:0]           word_count_out,
    output logic [7:0]            error_count_out
);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic [1:0]            arm_q;
    logic [4:0]            len_q, len_d;
    logic [4:0]            bitcnt_q, bitcnt_d;
    logic [MAX_LENGTH-1:0] shreg_q, shreg_d;
    logic [MAX_LENGTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [7:0]            ecnt_q, ecnt_d;

    logic                  cs_s2, cs_rise, cs_fall, sclk_rise, mosi_bit;
    logic [4:0]            eff_len;
    logic [MAX_LENGTH-1:0] len_mask;

    // Stage index: [0] = first flop, [1] = synchronized level, [2] = edge-detect history.
    assign cs_s2     = cs_sync_q[1];
    assign cs_rise   =  cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall   = ~cs_sync_q[1] &  cs_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    // Data as seen just before the detected sclk rise; mode-0 transmitters
    // change mosi on the falling edge, so this is the stable setup value.
    assign mosi_bit  = mosi_sync_q[2];

    always_comb begin
        eff_len = data_length_in;
        if (data_length_in == 5'd0 || data_length_in > 5'(MAX_LENGTH)) begin
            eff_len = 5'(MAX_LENGTH);
        end
    end

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LENGTH; i++) begin
            len_mask[i] = (i < 32'(len_q));
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        wcnt_d   = wcnt_q;
        ecnt_d   = ecnt_q;
        unique case (state_q)
            // The synchronizers reset to "cs high", so their stage-2 output
            // only reflects the pin two cycles after reset; arm_q holds off
            // until then so a frame already in progress is never mistaken
            // for a fresh cs falling edge.
            WAIT_IDLE: begin
                if (arm_q[1] && cs_s2) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cs_fall) begin
                    len_d    = eff_len;
                    bitcnt_d = '0;
                    shreg_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // cs edge wins over a coincident sclk edge.
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bitcnt_q == len_q) begin
                        data_d  = shreg_q & len_mask;
                        valid_d = 1'b1;
                        wcnt_d  = wcnt_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                        if (ecnt_q != 8'hFF) begin
                            ecnt_d = ecnt_q + 8'd1;
                        end
                    end
                end else if (sclk_rise && !cs_s2) begin
                    shreg_d = {shreg_q[MAX_LENGTH-2:0], mosi_bit};
                    if (bitcnt_q != 5'd31) begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q     <= WAIT_IDLE;
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            arm_q       <= '0;
            len_q       <= 5'(MAX_LENGTH);
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            wcnt_q      <= '0;
            ecnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= {cs_sync_q[1:0], cs_in};
            sclk_sync_q <= {sclk_sync_q[1:0], sclk_in};
            mosi_sync_q <= {mosi_sync_q[1:0], mosi_in};
            arm_q       <= {arm_q[0], 1'b1};
            len_q       <= len_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            wcnt_q      <= wcnt_d;
            ecnt_q      <= ecnt_d;
        end
    end

    assign data_out        = data_q;
    assign data_valid_out  = valid_q;
    assign error_out       = err_q;
    assign busy_out        = (state_q == SHIFT);
    assign word_count_out  = wcnt_q;
    assign error_count_out = ecnt_q;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: directed SPI frames, expected strobes
// queued in a scoreboard and checked by a monitor when the DUT strobes.
module tb_spi_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dlen;
    logic        sclk, mosi, cs;
    logic [15:0] data_out;
    logic        data_valid_out, busy_out, error_out;
    logic [15:0] word_count_out;
    logic [7:0]  error_count_out;

    always #5 clk = ~clk;

    spi_rx #(.MAX_LENGTH(16)) dut (
        .clock_in        (clk),
        .reset_in        (rst),
        .data_length_in  (dlen),
        .sclk_in         (sclk),
        .mosi_in         (mosi),
        .cs_in           (cs),
        .data_out        (data_out),
        .data_valid_out  (data_valid_out),
        .busy_out        (busy_out),
        .error_out       (error_out),
        .word_count_out  (word_count_out),
        .error_count_out (error_count_out)
    );

    typedef struct packed {
        logic        err;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [15:0] exp_data;
    int          exp_wc, exp_ec;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_good(input logic [31:0] w, input int len);
        logic [31:0] m;
        m = (32'd1 << len) - 32'd1;
        exp_data = 16'(w & m);
        exp_wc   = (exp_wc + 1) % 65536;
        sb.push_back({1'b0, exp_data});
    endtask

    task automatic expect_err();
        if (exp_ec < 255) exp_ec++;
        sb.push_back({1'b1, exp_data});
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        cyc(4);
        sclk = 1'b1;
        cyc(4);
        sclk = 1'b0;
    endtask

    // n sclk pulses, MSB first; data_length_in changes to chg_len when bit chg_at is sent
    task automatic frame_bits(input logic [31:0] w, input int n, input int chg_at, input logic [4:0] chg_len);
        cs = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            if (i == chg_at) dlen = chg_len;
            send_bit(w[i]);
        end
        cyc(4);
        cs = 1'b1;
    endtask

    // cs was just raised at a negedge: check the strobe lands exactly in
    // the cycle after the second following edge and lasts one cycle
    task automatic end_timed(input logic err);
        logic [1:0] want;
        want = err ? 2'b01 : 2'b10;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_strobe", 32'({data_valid_out, error_out}), 32'd0);
        chk("busy_hold", 32'(busy_out), 32'd1);
        @(posedge clk); #1;
        chk("strobe", 32'({data_valid_out, error_out}), 32'(want));
        chk("busy_fall", 32'(busy_out), 32'd0);
        @(posedge clk); #1;
        chk("strobe_1cyc", 32'({data_valid_out, error_out}), 32'd0);
        cyc(4);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_data"}, 32'(data_out), 32'(exp_data));
        chk({tag, "_wc"}, 32'(word_count_out), 32'(exp_wc));
        chk({tag, "_ec"}, 32'(error_count_out), 32'(exp_ec));
    endtask

    task automatic model_reset();
        exp_data = '0;
        exp_wc   = 0;
        exp_ec   = 0;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (data_valid_out || error_out)) begin
            exp_t e;
            chk("strobe_excl", 32'(data_valid_out & error_out), 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_kind", 32'(error_out), 32'(e.err));
                chk("sb_data", 32'(data_out), 32'(e.data));
            end
        end
    end

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        dlen = 5'd16;
        model_reset();
        cyc(3);
        @(posedge clk); #1;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid_out), 32'd0);
        chk("rst_err", 32'(error_out), 32'd0);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_wc", 32'(word_count_out), 32'd0);
        chk("rst_ec", 32'(error_count_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(4);

        // full-length word
        dlen = 5'd16;
        expect_good(32'hA5C3, 16);
        frame_bits(32'hA5C3, 16, -1, 5'd0);
        end_timed(1'b0);
        chk_state("a5c3");

        // 12-bit word, length input changed mid-frame
        dlen = 5'd12;
        expect_good(32'h0ABC, 12);
        frame_bits(32'h0ABC, 12, 5, 5'd8);
        end_timed(1'b0);
        chk_state("abc");

        // length boundaries: 1, 0 -> 16, 20 -> 16
        dlen = 5'd1;
        expect_good(32'h1, 1);
        frame_bits(32'h1, 1, -1, 5'd0);
        end_timed(1'b0);
        dlen = 5'd0;
        expect_good(32'h8001, 16);
        frame_bits(32'h8001, 16, -1, 5'd0);
        end_timed(1'b0);
        dlen = 5'd20;
        expect_good(32'h7FFE, 16);
        frame_bits(32'h7FFE, 16, -1, 5'd0);
        end_timed(1'b0);
        chk_state("lenbound");

        // short and overlong frames
        dlen = 5'd16;
        expect_err();
        frame_bits(32'h3FF, 10, -1, 5'd0);
        end_timed(1'b1);
        expect_err();
        frame_bits(32'h1FFFF, 17, -1, 5'd0);
        end_timed(1'b1);
        chk_state("malformed");

        // reset in the middle of a frame: remainder must be ignored
        cs = 1'b0;
        cyc(4);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 9; i++) send_bit(1'b0);
        cyc(4);
        cs = 1'b1;
        cyc(10);
        chk_state("midrst");
        chk("midrst_busy", 32'(busy_out), 32'd0);
        expect_good(32'h1234, 16);
        frame_bits(32'h1234, 16, -1, 5'd0);
        end_timed(1'b0);
        chk_state("1234");

        // back-to-back frames with minimum cs gap
        expect_good(32'h0001, 16);
        expect_good(32'hFFFF, 16);
        frame_bits(32'h0001, 16, -1, 5'd0);
        cyc(2);
        frame_bits(32'hFFFF, 16, -1, 5'd0);
        cyc(10);
        chk_state("b2b");

        // zero-bit frames: error counter saturates
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cyc(4);
        for (int i = 0; i < 260; i++) begin
            expect_err();
            cs = 1'b0;
            cyc(3);
            cs = 1'b1;
            cyc(3);
        end
        cyc(10);
        chk_state("sat");

        for (int i = 0; i < 200 && sb.size() != 0; i++) cyc(1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
